// File: rtl/moving_avg_nch.sv
// Multi-channel boxcar filter: per-channel WIN-deep ring buffer with a running sum,
// registered as either the raw window sum or the sum divided by WIN.
module moving_avg_nch #(
  parameter int NCH      = 3,
  parameter int DW       = 2,
  parameter int LOG2_WIN = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         in_valid,
  input  logic [NCH*DW-1:0]            in_data,
  input  logic                         mode,
  input  logic                         out_en,
  output logic                         out_valid,
  output logic [NCH*(DW+LOG2_WIN)-1:0] out_data,
  output logic [LOG2_WIN:0]            fill,
  output logic                         full
);

  localparam int WIN = 1 << LOG2_WIN;
  localparam int SW  = DW + LOG2_WIN;
  localparam int FW  = LOG2_WIN + 1;

  logic [DW-1:0]       r_buf [NCH][WIN];
  logic [SW-1:0]       r_sum [NCH];
  logic [LOG2_WIN-1:0] r_wr_ptr;
  logic [FW-1:0]       r_fill;
  logic [NCH*SW-1:0]   r_out_data_p1;
  logic                r_vld_p1;

  logic                w_acc;
  logic [DW-1:0]       w_new     [NCH];
  logic [SW-1:0]       w_sum_nxt [NCH];
  logic [NCH*SW-1:0]   w_out_nxt;

  // Average divides by WIN even while filling: the window is zero-padded.
  function automatic logic [SW-1:0] scale_sum(input logic [SW-1:0] sum, input logic raw);
    logic [SW-1:0] res;
    if (raw) res = sum;
    else     res = sum >> LOG2_WIN;
    return res;
  endfunction

  assign w_acc = in_valid & ~clr;

  always_comb begin
    w_out_nxt = '0;
    for (int c = 0; c < NCH; c++) begin
      w_new[c]     = in_data[c*DW +: DW];
      w_sum_nxt[c] = r_sum[c] + SW'(w_new[c]) - SW'(r_buf[c][r_wr_ptr]);
      w_out_nxt[c*SW +: SW] = scale_sum(w_sum_nxt[c], mode);
    end
  end

  // Stage p0 -> p1: history update and output register share the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        r_sum[c] <= '0;
        for (int w = 0; w < WIN; w++) r_buf[c][w] <= '0;
      end
      r_wr_ptr      <= '0;
      r_fill        <= '0;
      r_out_data_p1 <= '0;
      r_vld_p1      <= 1'b0;
    end else if (clr) begin
      for (int c = 0; c < NCH; c++) begin
        r_sum[c] <= '0;
        for (int w = 0; w < WIN; w++) r_buf[c][w] <= '0;
      end
      r_wr_ptr      <= '0;
      r_fill        <= '0;
      r_out_data_p1 <= '0;
      r_vld_p1      <= 1'b0;
    end else begin
      r_vld_p1 <= w_acc;
      if (w_acc) begin
        for (int c = 0; c < NCH; c++) begin
          r_sum[c]           <= w_sum_nxt[c];
          r_buf[c][r_wr_ptr] <= w_new[c];
        end
        r_wr_ptr      <= r_wr_ptr + LOG2_WIN'(1);
        r_out_data_p1 <= w_out_nxt;
        if (r_fill != FW'(WIN)) r_fill <= r_fill + FW'(1);
      end
    end
  end

  assign out_data  = out_en ? r_out_data_p1 : '0;
  assign out_valid = out_en & r_vld_p1;
  assign fill      = r_fill;
  assign full      = (r_fill == FW'(WIN));

endmodule
